// File: rtl/freq_pkg.sv
// freq_pkg: shared sizing constants and controller state encoding for the symbol frequency counter
package freq_pkg;
    localparam int SYM_W  = 9;
    localparam int FREQ_W = 12;
    localparam int DEPTH  = 286;
    localparam int ADDR_W = 24;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COUNT,
        ST_DRAIN,
        ST_DUMP,
        ST_FINISH
    } state_t;
endpackage

// File: rtl/freq_rmw_pipe.sv
// freq_rmw_pipe: two-stage read-modify-write increment with write-to-read forwarding and saturation
module freq_rmw_pipe #(
    parameter int SYM_W  = freq_pkg::SYM_W,
    parameter int FREQ_W = freq_pkg::FREQ_W,
    parameter int DEPTH  = freq_pkg::DEPTH,
    parameter int ADDR_W = freq_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc,
    input  logic [SYM_W-1:0]  sym,
    input  logic [FREQ_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [FREQ_W-1:0] wr_data,
    output logic              sat,
    output logic              bad
);
    localparam logic [FREQ_W-1:0] MAX = '1;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic              lw_valid;
    logic [ADDR_W-1:0] lw_addr;
    logic [FREQ_W-1:0] lw_data;
    logic [FREQ_W-1:0] base;
    assign rd_addr = ADDR_W'(sym);
    assign bad     = acc && (32'(sym) >= DEPTH);
    // The RAM read misses a write to the same address issued in the same cycle, so take that value instead
    always_comb begin
        base    = (lw_valid && lw_addr == s1_addr) ? lw_data : rd_data;
        wr_en   = s1_valid;
        wr_addr = s1_addr;
        wr_data = s1_valid ? ((base == MAX) ? MAX : base + 1'b1) : '0;
        sat     = s1_valid && base == MAX;
    end
    // Stage 1 and last-write registers; out-of-range symbols never reach stage 1
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            lw_valid <= 1'b0;
            lw_addr  <= '0;
            lw_data  <= '0;
        end else begin
            s1_valid <= acc && !bad;
            s1_addr  <= rd_addr;
            lw_valid <= s1_valid;
            lw_addr  <= s1_addr;
            lw_data  <= wr_data;
        end
    end
endmodule

// File: rtl/freq_count_scheduler.sv
// freq_count_scheduler: clears an external frequency RAM, counts a symbol stream into it, then dumps it
module freq_count_scheduler
    import freq_pkg::*;
#(
    parameter int SYM_W  = freq_pkg::SYM_W,
    parameter int FREQ_W = freq_pkg::FREQ_W,
    parameter int DEPTH  = freq_pkg::DEPTH,
    parameter int ADDR_W = freq_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] sym_count,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym_data,
    output logic              sym_ready,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [FREQ_W-1:0] ram_rd_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [FREQ_W-1:0] ram_wr_data,
    output logic              out_valid,
    output logic [SYM_W-1:0]  out_sym,
    output logic [FREQ_W-1:0] out_freq,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              bad_sym
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] remain;
    logic              phase;
    logic              acc, idx_last;
    logic              p_wr_en, p_sat, p_bad;
    logic [ADDR_W-1:0] p_rd_addr, p_wr_addr;
    logic [FREQ_W-1:0] p_wr_data;
    freq_rmw_pipe #(
        .SYM_W (SYM_W),
        .FREQ_W(FREQ_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_pipe (
        .clk    (clk),
        .reset  (reset),
        .acc    (acc),
        .sym    (sym_data),
        .rd_data(ram_rd_data),
        .rd_addr(p_rd_addr),
        .wr_en  (p_wr_en),
        .wr_addr(p_wr_addr),
        .wr_data(p_wr_data),
        .sat    (p_sat),
        .bad    (p_bad)
    );
    assign idx_last = idx == ADDR_W'(DEPTH - 1);
    assign acc      = sym_valid && sym_ready;
    // Outputs: the RAM ports are shared between clearing, counting and dumping by state
    always_comb begin
        sym_ready   = state == ST_COUNT;
        busy        = state != ST_IDLE;
        done        = state == ST_FINISH;
        out_valid   = state == ST_DUMP && phase;
        out_sym     = out_valid ? idx[SYM_W-1:0] : '0;
        out_freq    = out_valid ? ram_rd_data : '0;
        ram_rd_addr = (state == ST_COUNT) ? p_rd_addr : idx;
        ram_wr_en   = (state == ST_CLEAR) || p_wr_en;
        ram_wr_addr = (state == ST_CLEAR) ? idx : p_wr_addr;
        ram_wr_data = (state == ST_CLEAR) ? '0 : p_wr_data;
    end
    // Next state: an empty run skips counting and goes straight to the dump
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (start) state_n = ST_CLEAR;
            ST_CLEAR:  if (idx_last) state_n = (remain == '0) ? ST_DUMP : ST_COUNT;
            ST_COUNT:  if (acc && remain == ADDR_W'(1)) state_n = ST_DRAIN;
            ST_DRAIN:  state_n = ST_DUMP;
            ST_DUMP:   if (out_valid && out_ready && idx_last) state_n = ST_FINISH;
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end
    // State register, address walker, remaining-symbol counter and sticky flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            remain   <= '0;
            phase    <= 1'b0;
            overflow <= 1'b0;
            bad_sym  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && start) begin
                remain   <= sym_count;
                overflow <= 1'b0;
                bad_sym  <= 1'b0;
            end
            if (acc) remain <= remain - 1'b1;
            if (p_sat) overflow <= 1'b1;
            if (p_bad) bad_sym <= 1'b1;
            if (state == ST_CLEAR) idx <= idx_last ? '0 : idx + 1'b1;
            if (state == ST_DUMP) begin
                if (!phase) begin
                    phase <= 1'b1;
                end else if (out_ready) begin
                    phase <= 1'b0;
                    idx   <= idx_last ? '0 : idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_freq_count_scheduler.sv
// tb_freq_count_scheduler: scoreboard bench with an external RAM model for freq_count_scheduler
module tb_freq_count_scheduler;
    localparam int SYM_W  = 9;
    localparam int FREQ_W = 12;
    localparam int DEPTH  = 286;
    localparam int ADDR_W = 24;
    localparam int FMAX   = 4095;
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] sym_count = '0;
    logic              sym_valid = 1'b0;
    logic [SYM_W-1:0]  sym_data = '0;
    logic              sym_ready;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [FREQ_W-1:0] ram_rd_data;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [FREQ_W-1:0] ram_wr_data;
    logic              out_valid;
    logic [SYM_W-1:0]  out_sym;
    logic [FREQ_W-1:0] out_freq;
    logic              out_ready = 1'b0;
    logic              busy, done, overflow, bad_sym;
    logic [FREQ_W-1:0] mem [0:511];
    int vectors = 0;
    int miscompares = 0;
    int bad_wr = 0;
    typedef struct {
        int sym;
        int freq;
    } ent_t;
    ent_t sb[$];
    always #5 clk = ~clk;
    freq_count_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sym_count  (sym_count),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .out_valid  (out_valid),
        .out_sym    (out_sym),
        .out_freq   (out_freq),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .bad_sym    (bad_sym)
    );
    // Registered-read RAM: a read in the same cycle as a write returns the old contents
    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr[8:0]];
        if (ram_wr_en) mem[ram_wr_addr[8:0]] <= ram_wr_data;
    end
    // Writes are illegal to out-of-range addresses or while idle
    always @(negedge clk) begin
        if (reset && ram_wr_en && (ram_wr_addr >= ADDR_W'(DEPTH) || !busy)) bad_wr++;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run(input string name, input int syms[$], input int bp_at, input int bp_len);
        int exp_f[DEPTH];
        bit exp_ov, exp_bad, acc, started;
        int i, guard, gaps, held, wr0;
        ent_t e;
        logic [SYM_W-1:0] hs;
        logic [FREQ_W-1:0] hf;
        exp_ov = 0;
        exp_bad = 0;
        for (int k = 0; k < DEPTH; k++) exp_f[k] = 0;
        foreach (syms[k]) begin
            if (syms[k] >= DEPTH) exp_bad = 1;
            else if (exp_f[syms[k]] == FMAX) exp_ov = 1;
            else exp_f[syms[k]]++;
        end
        for (int k = 0; k < DEPTH; k++) sb.push_back('{k, exp_f[k]});
        wr0 = bad_wr;
        start = 1'b1;
        sym_count = ADDR_W'(syms.size());
        tick();
        start = 1'b0;
        i = 0;
        guard = 0;
        gaps = 0;
        started = 0;
        while (i < syms.size() && guard < 10000) begin
            sym_valid = 1'b1;
            sym_data = SYM_W'(syms[i]);
            acc = sym_ready;
            if (started && !acc) gaps++;
            if (acc) started = 1;
            tick();
            guard++;
            if (acc) i++;
        end
        sym_valid = 1'b0;
        vectors++;
        if (i != syms.size() || gaps != 0) begin
            miscompares++;
            $display("FAIL %s accept: accepted %0d with %0d gaps, required %0d with 0 gaps", name, i, gaps, syms.size());
        end
        guard = 0;
        held = 0;
        while (sb.size() > 0 && guard < 5000) begin
            out_ready = !(out_valid && out_sym == SYM_W'(bp_at) && held < bp_len);
            if (out_valid && !out_ready) begin
                if (held == 0) begin
                    hs = out_sym;
                    hf = out_freq;
                end else begin
                    vectors++;
                    if (out_sym !== hs || out_freq !== hf) begin
                        miscompares++;
                        $display("FAIL %s hold: sym %0d freq %0d, required sym %0d freq %0d", name, out_sym, out_freq, hs, hf);
                    end
                end
                held++;
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                vectors++;
                if (out_sym !== SYM_W'(e.sym) || out_freq !== FREQ_W'(e.freq)) begin
                    miscompares++;
                    $display("FAIL %s entry: sym %0d freq %0d, required sym %0d freq %0d", name, out_sym, out_freq, e.sym, e.freq);
                end
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s dump timeout: %0d entries left, required 0", name, sb.size());
            sb.delete();
        end
        if (bp_at >= 0) begin
            vectors++;
            if (held != bp_len) begin
                miscompares++;
                $display("FAIL %s stall: held %0d cycles, required %0d", name, held, bp_len);
            end
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done pulse: %b, required 1", name, done);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: done %b busy %b, required 0 0", name, done, busy);
        end
        vectors++;
        if (overflow !== exp_ov || bad_sym !== exp_bad) begin
            miscompares++;
            $display("FAIL %s flags: overflow %b bad_sym %b, required %b %b", name, overflow, bad_sym, exp_ov, exp_bad);
        end
        vectors++;
        if (bad_wr != wr0) begin
            miscompares++;
            $display("FAIL %s illegal writes: %0d, required 0", name, bad_wr - wr0);
        end
    endtask
    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({busy, sym_ready, ram_wr_en, out_valid, done, overflow, bad_sym} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset outputs: %b, required 0000000", {busy, sym_ready, ram_wr_en, out_valid, done, overflow, bad_sym});
        end
        reset = 1'b1;
        tick();
    endtask
    task automatic test_basic;
        int q[$];
        q.push_back(5);
        q.push_back(7);
        q.push_back(5);
        q.push_back(5);
        run("basic", q, -1, 0);
    endtask
    task automatic test_forwarding;
        int q[$];
        repeat (6) q.push_back(65);
        q.push_back(66);
        q.push_back(65);
        run("forward", q, -1, 0);
    endtask
    task automatic test_saturation;
        int q[$];
        repeat (4100) q.push_back(1);
        run("saturate", q, -1, 0);
    endtask
    task automatic test_bad_and_empty;
        int q[$];
        q.push_back(300);
        q.push_back(2);
        q.push_back(300);
        run("bad_sym", q, -1, 0);
        q.delete();
        run("empty", q, -1, 0);
    endtask
    task automatic test_backpressure;
        int q[$];
        q.push_back(10);
        q.push_back(10);
        q.push_back(285);
        q.push_back(0);
        run("backpressure", q, 10, 5);
    endtask
    task automatic test_reset_mid_count;
        int q[$];
        int i, guard;
        bit acc;
        start = 1'b1;
        sym_count = ADDR_W'(10);
        tick();
        start = 1'b0;
        i = 0;
        guard = 0;
        while (i < 2 && guard < 1000) begin
            sym_valid = 1'b1;
            sym_data = SYM_W'(3);
            acc = sym_ready;
            tick();
            guard++;
            if (acc) i++;
        end
        vectors++;
        if (i != 2) begin
            miscompares++;
            $display("FAIL abort accepts: %0d, required 2", i);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || ram_wr_en !== 1'b0 || sym_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort reset: busy %b wr_en %b ready %b, required 0 0 0", busy, ram_wr_en, sym_ready);
        end
        reset = 1'b1;
        sym_valid = 1'b0;
        tick();
        vectors++;
        if (ram_wr_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort quiet: wr_en %b busy %b, required 0 0", ram_wr_en, busy);
        end
        q.push_back(3);
        run("reclear", q, -1, 0);
    endtask
    initial begin
        for (int k = 0; k < 512; k++) mem[k] = FREQ_W'(12'h5A5 ^ k);
        test_reset();
        test_basic();
        test_forwarding();
        test_saturation();
        test_bad_and_empty();
        test_backpressure();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
